// File: rtl/l1_d_cache.sv
// L1 data cache: 8-way set-associative, write-through / no-write-allocate, 4-beat line refill.
// Define L1_D_TRACE_EN to print a simulation trace line on every cpu_enable pulse.
module l1_d_cache #(
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned NUM_WAYS   = 8,
  parameter int unsigned LINE_BYTES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  output logic         cpu_enable,
  input  logic         write_enable_in,
  input  logic [63:0]  write_data_in,
  input  logic [63:0]  address_in,
  input  logic [2:0]   write_size_in,
  input  logic         CLF,
  input  logic [127:0] data_in,
  input  logic         lower_ack,
  output logic         lower_req,
  output logic [127:0] data_out,
  output logic         write_enable_out,
  output logic [63:0]  write_data_out,
  output logic [63:0]  address_out,
  output logic [2:0]   write_size_out,
  output logic         CLF_out,
  input  logic [31:0]  nops
);

  localparam int unsigned IdxW  = $clog2(NUM_SETS);
  localparam int unsigned WayW  = $clog2(NUM_WAYS);
  localparam int unsigned OffW  = $clog2(LINE_BYTES);
  localparam int unsigned TagW  = 64 - IdxW - OffW;
  localparam int unsigned LineW = LINE_BYTES * 8;
  localparam int unsigned Beats = LINE_BYTES / 16;
  localparam int unsigned BeatW = $clog2(Beats);

  typedef enum logic [2:0] {
    StIdle, StLookup, StRefill, StWriteWait, StFlushWait, StResp
  } state_e;

  state_e state_q, state_d;

  logic [63:0]       addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [2:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              clf_q, clf_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [LineW-1:0]  line_buf_q, line_buf_d;
  logic [127:0]      resp_q, resp_d;
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [WayW-1:0]   rr_q [NUM_SETS];
  logic [WayW-1:0]   rr_d [NUM_SETS];

  logic [TagW-1:0]   tag_mem  [NUM_SETS][NUM_WAYS];
  logic [LineW-1:0]  data_mem [NUM_SETS][NUM_WAYS];

  logic [IdxW-1:0]   idx;
  logic [TagW-1:0]   tag;
  logic [OffW-5:0]   chunk;
  logic              hit;
  logic [WayW-1:0]   hit_way;
  logic [LineW-1:0]  hit_line;
  logic [LineW-1:0]  merged_line;
  logic [LineW-1:0]  fill_line;
  logic              refill_done;
  int unsigned       wr_off;
  int unsigned       wr_len;

  logic              data_we;
  logic              tag_we;
  logic [WayW-1:0]   wr_way;
  logic [LineW-1:0]  wr_line;

  logic unused_nops;
  assign unused_nops = ^nops;

  assign idx      = addr_q[OffW +: IdxW];
  assign tag      = addr_q[63 -: TagW];
  assign chunk    = addr_q[OffW-1:4];
  assign wr_off   = 32'(addr_q[OffW-1:0]);
  assign wr_len   = (size_q >= 3'd3) ? 32'd8 : (32'd1 << size_q);
  assign hit_line = data_mem[idx][hit_way];

  assign refill_done = (state_q == StRefill) && lower_ack && (beat_q == BeatW'(Beats - 1));

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && (tag_mem[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end
  end

  // Bytes past the end of the line are dropped locally; the lower level gets the full write.
  always_comb begin
    merged_line = hit_line;
    for (int unsigned b = 0; b < 8; b++) begin
      if ((b < wr_len) && ((wr_off + b) < LINE_BYTES)) begin
        merged_line[(wr_off + b) * 8 +: 8] = wdata_q[b * 8 +: 8];
      end
    end
  end

  always_comb begin
    fill_line = line_buf_q;
    fill_line[beat_q * 128 +: 128] = data_in;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (enable) state_d = StLookup;
      StLookup: begin
        if (clf_q)     state_d = StFlushWait;
        else if (we_q) state_d = StWriteWait;
        else if (hit)  state_d = StResp;
        else           state_d = StRefill;
      end
      StRefill:    if (refill_done) state_d = StResp;
      StWriteWait: if (lower_ack) state_d = StResp;
      StFlushWait: if (lower_ack) state_d = StResp;
      StResp:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    we_d       = we_q;
    clf_d      = clf_q;
    beat_d     = beat_q;
    line_buf_d = line_buf_q;
    resp_d     = resp_q;
    valid_d    = valid_q;
    rr_d       = rr_q;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    wr_way     = hit_way;
    wr_line    = merged_line;

    if ((state_q == StIdle) && enable) begin
      addr_d  = address_in;
      wdata_d = write_data_in;
      size_d  = write_size_in;
      we_d    = write_enable_in;
      clf_d   = CLF;
      beat_d  = '0;
    end

    if (state_q == StLookup) begin
      if (clf_q) begin
        if (hit) valid_d[idx][hit_way] = 1'b0;
        resp_d = '0;
      end else if (we_q) begin
        data_we = hit;
        resp_d  = '0;
      end else if (hit) begin
        resp_d = hit_line[chunk * 128 +: 128];
      end
    end

    if ((state_q == StRefill) && lower_ack) begin
      line_buf_d = fill_line;
      beat_d     = beat_q + BeatW'(1);
      if (refill_done) begin
        data_we                = 1'b1;
        tag_we                 = 1'b1;
        wr_way                 = rr_q[idx];
        wr_line                = fill_line;
        valid_d[idx][rr_q[idx]] = 1'b1;
        rr_d[idx]              = rr_q[idx] + WayW'(1);
        resp_d                 = fill_line[chunk * 128 +: 128];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      clf_q      <= 1'b0;
      beat_q     <= '0;
      line_buf_q <= '0;
      resp_q     <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      we_q       <= we_d;
      clf_q      <= clf_d;
      beat_q     <= beat_d;
      line_buf_q <= line_buf_d;
      resp_q     <= resp_d;
      valid_q    <= valid_d;
      rr_q       <= rr_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[idx][wr_way] <= wr_line;
    if (tag_we)  tag_mem[idx][wr_way]  <= tag;
  end

  // Output logic
  always_comb begin
    cpu_enable       = 1'b0;
    data_out         = '0;
    lower_req        = 1'b0;
    write_enable_out = 1'b0;
    write_data_out   = '0;
    address_out      = '0;
    write_size_out   = '0;
    CLF_out          = 1'b0;
    unique case (state_q)
      StRefill: begin
        lower_req   = 1'b1;
        address_out = {addr_q[63:OffW], {OffW{1'b0}}};
      end
      StWriteWait: begin
        lower_req        = 1'b1;
        write_enable_out = 1'b1;
        write_data_out   = wdata_q;
        address_out      = addr_q;
        write_size_out   = size_q;
      end
      StFlushWait: begin
        lower_req   = 1'b1;
        CLF_out     = 1'b1;
        address_out = {addr_q[63:OffW], {OffW{1'b0}}};
      end
      StResp: begin
        cpu_enable = 1'b1;
        data_out   = resp_q;
      end
      default: ;
    endcase
  end

`ifdef L1_D_TRACE_EN
  logic trace_hit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace_hit_q <= 1'b0;
    end else if (state_q == StLookup) begin
      trace_hit_q <= hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state_q == StResp)) begin
      $display("l1_d_cache nops=%0d op=%s addr=%h %s data=%h", nops,
               clf_q ? "F" : (we_q ? "W" : "R"), addr_q, trace_hit_q ? "hit" : "miss", resp_q);
    end
  end
`endif

endmodule

// File: tb/tb_l1_d_cache.sv
// Self-checking bench for l1_d_cache: directed test-plan scenarios plus randomized traffic
// checked against a byte-level cache/L2 model.
module tb_l1_d_cache;

  localparam int NSets = 64;
  localparam int NWays = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         cpu_enable;
  logic         write_enable_in;
  logic [63:0]  write_data_in;
  logic [63:0]  address_in;
  logic [2:0]   write_size_in;
  logic         CLF;
  logic [127:0] data_in;
  logic         lower_ack;
  logic         lower_req;
  logic [127:0] data_out;
  logic         write_enable_out;
  logic [63:0]  write_data_out;
  logic [63:0]  address_out;
  logic [2:0]   write_size_out;
  logic         CLF_out;
  logic [31:0]  nops;

  l1_d_cache dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .cpu_enable       (cpu_enable),
    .write_enable_in  (write_enable_in),
    .write_data_in    (write_data_in),
    .address_in       (address_in),
    .write_size_in    (write_size_in),
    .CLF              (CLF),
    .data_in          (data_in),
    .lower_ack        (lower_ack),
    .lower_req        (lower_req),
    .data_out         (data_out),
    .write_enable_out (write_enable_out),
    .write_data_out   (write_data_out),
    .address_out      (address_out),
    .write_size_out   (write_size_out),
    .CLF_out          (CLF_out),
    .nops             (nops)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: lower-level byte memory plus cache contents per set/way.
  logic [7:0]  l2_mem [logic [63:0]];
  bit          m_valid [NSets][NWays];
  logic [51:0] m_tag   [NSets][NWays];
  logic [7:0]  m_data  [NSets][NWays][64];
  int          m_rr    [NSets];

  // Observations from the last transaction
  bit           obs_req, obs_we, obs_clf, obs_timeout;
  logic [63:0]  obs_addr, obs_wdata;
  logic [2:0]   obs_size;
  logic [127:0] obs_data;
  int           obs_lat;
  logic [263:0] obs_idle_bus;

  function automatic logic [7:0] l2_byte(input logic [63:0] a);
    if (l2_mem.exists(a)) return l2_mem[a];
    // Low byte of each beat holds the beat number; other bytes vary with the line address.
    if (a[3:0] == 4'h0) return {6'b0, a[5:4]};
    return a[19:12] ^ a[11:4] ^ {4'h0, a[3:0]} ^ 8'hA5;
  endfunction

  function automatic logic [127:0] l2_beat(input logic [63:0] la, input int k);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = l2_byte(la + 64'(k * 16 + i));
    return r;
  endfunction

  function automatic int m_find(input logic [63:0] a);
    int s = int'(a[11:6]);
    for (int w = 0; w < NWays; w++) if (m_valid[s][w] && m_tag[s][w] == a[63:12]) return w;
    return -1;
  endfunction

  function automatic logic [127:0] m_read(input logic [63:0] a, output bit miss);
    int s = int'(a[11:6]);
    int w = m_find(a);
    int c = int'(a[5:4]);
    logic [127:0] r;
    miss = (w < 0);
    if (miss) begin
      w = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % NWays;
      m_valid[s][w] = 1'b1;
      m_tag[s][w] = a[63:12];
      for (int i = 0; i < 64; i++) m_data[s][w][i] = l2_byte({a[63:6], 6'b0} + 64'(i));
    end
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = m_data[s][w][c*16 + i];
    return r;
  endfunction

  function automatic void m_write(input logic [63:0] a, input logic [63:0] wd,
                                  input logic [2:0] sz);
    int s = int'(a[11:6]);
    int w = m_find(a);
    int off = int'(a[5:0]);
    int n = (sz >= 3) ? 8 : (1 << sz);
    for (int b = 0; b < n; b++) begin
      if (w >= 0 && off + b < 64) m_data[s][w][off + b] = wd[b*8 +: 8];
      l2_mem[a + 64'(b)] = wd[b*8 +: 8];
    end
  endfunction

  function automatic void m_flush(input logic [63:0] a);
    int w = m_find(a);
    if (w >= 0) m_valid[int'(a[11:6])][w] = 1'b0;
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < NSets; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NWays; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  // Drives one request, plays the lower level (random ack gaps) and records what was seen.
  task automatic run_op(input bit is_wr, input bit is_clf, input logic [63:0] a,
                        input logic [63:0] wd, input logic [2:0] sz);
    int k = 0;
    int cyc = 0;
    bit done = 0;
    obs_req = 0; obs_we = 0; obs_clf = 0; obs_timeout = 0;
    obs_addr = '0; obs_wdata = '0; obs_size = '0; obs_data = '0; obs_lat = 0;
    @(negedge clk);
    enable = 1'b1; write_enable_in = is_wr; CLF = is_clf; address_in = a;
    write_data_in = wd; write_size_in = sz; nops = nops + 1;
    while (!done && cyc < 80) begin
      @(posedge clk); #1; cyc++;
      if (lower_ack) begin k++; lower_ack = 1'b0; end
      if (cpu_enable) begin
        obs_data = data_out; obs_lat = cyc; enable = 1'b0; done = 1;
      end else if (lower_req) begin
        if (!obs_req) begin
          obs_req = 1; obs_addr = address_out; obs_we = write_enable_out;
          obs_clf = CLF_out; obs_wdata = write_data_out; obs_size = write_size_out;
        end
        if ($urandom_range(0, 2) != 0) begin
          lower_ack = 1'b1;
          data_in = l2_beat({a[63:6], 6'b0}, k);
        end
      end
    end
    if (!done) begin obs_timeout = 1; enable = 1'b0; lower_ack = 1'b0; end
    @(posedge clk); #1;
    obs_idle_bus = {cpu_enable, lower_req, data_out, write_enable_out, write_data_out,
                    address_out, write_size_out, CLF_out};
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 0; write_enable_in = 0; write_data_in = '0; address_in = '0;
    write_size_in = '0; CLF = 0; data_in = '0; lower_ack = 0; nops = '0;
    m_reset();
    repeat (3) @(negedge clk);
    checks++; if (cpu_enable !== 1'b0) begin fails++; $display("FAIL rst_cpu_enable: got %0b want 0", cpu_enable); end
    checks++; if (lower_req !== 1'b0) begin fails++; $display("FAIL rst_lower_req: got %0b want 0", lower_req); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (data_out !== '0) begin fails++; $display("FAIL rst_data_out: got %h want 0", data_out); end
    checks++; if (address_out !== '0) begin fails++; $display("FAIL rst_address_out: got %h want 0", address_out); end
    checks++; if ({write_enable_out, CLF_out, write_size_out} !== 5'b0) begin fails++; $display("FAIL rst_ctl_out: got %b want 0", {write_enable_out, CLF_out, write_size_out}); end
    checks++; if (write_data_out !== '0) begin fails++; $display("FAIL rst_wdata_out: got %h want 0", write_data_out); end
  endtask

  task automatic test_cold_miss();
    bit miss;
    logic [127:0] exp = m_read(64'd8, miss);
    run_op(0, 0, 64'd8, '0, 3'd0);
    checks++; if (obs_timeout !== 1'b0) begin fails++; $display("FAIL cold_timeout: got %0b want 0", obs_timeout); end
    checks++; if (obs_req !== 1'b1) begin fails++; $display("FAIL cold_req: got %0b want 1", obs_req); end
    checks++; if (obs_addr !== 64'd0) begin fails++; $display("FAIL cold_addr: got %h want 0", obs_addr); end
    checks++; if (obs_we !== 1'b0) begin fails++; $display("FAIL cold_we: got %0b want 0", obs_we); end
    checks++; if (obs_data !== exp) begin fails++; $display("FAIL cold_data: got %h want %h", obs_data, exp); end
    checks++; if (obs_data[7:0] !== 8'h00) begin fails++; $display("FAIL cold_beat0: got %h want 00", obs_data[7:0]); end
  endtask

  task automatic test_read_hit();
    bit miss;
    logic [127:0] exp = m_read(64'd8, miss);
    run_op(0, 0, 64'd8, '0, 3'd0);
    checks++; if (obs_req !== 1'b0) begin fails++; $display("FAIL hit_req: got %0b want 0", obs_req); end
    checks++; if (obs_lat !== 2) begin fails++; $display("FAIL hit_latency: got %0d want 2", obs_lat); end
    checks++; if (obs_data !== exp) begin fails++; $display("FAIL hit_data: got %h want %h", obs_data, exp); end
    exp = m_read(64'h30, miss);
    run_op(0, 0, 64'h30, '0, 3'd0);
    checks++; if (obs_data !== exp) begin fails++; $display("FAIL hit_beat3: got %h want %h", obs_data, exp); end
    checks++; if (obs_data[7:0] !== 8'h03) begin fails++; $display("FAIL hit_beat3_tag: got %h want 03", obs_data[7:0]); end
  endtask

  task automatic test_write_hit();
    bit miss;
    logic [127:0] exp;
    m_write(64'd8, 64'hDEADBEEF_CAFEF00D, 3'd3);
    run_op(1, 0, 64'd8, 64'hDEADBEEF_CAFEF00D, 3'd3);
    checks++; if (obs_req !== 1'b1 || obs_we !== 1'b1) begin fails++; $display("FAIL wr_req_we: got %0b%0b want 11", obs_req, obs_we); end
    checks++; if (obs_addr !== 64'd8) begin fails++; $display("FAIL wr_addr: got %h want 8", obs_addr); end
    checks++; if (obs_size !== 3'd3) begin fails++; $display("FAIL wr_size: got %0d want 3", obs_size); end
    checks++; if (obs_wdata !== 64'hDEADBEEF_CAFEF00D) begin fails++; $display("FAIL wr_wdata: got %h", obs_wdata); end
    checks++; if (obs_data !== '0) begin fails++; $display("FAIL wr_data_out: got %h want 0", obs_data); end
    exp = m_read(64'd8, miss);
    run_op(0, 0, 64'd8, '0, 3'd0);
    checks++; if (obs_req !== 1'b0) begin fails++; $display("FAIL wr_rb_req: got %0b want 0", obs_req); end
    checks++; if (obs_data !== exp) begin fails++; $display("FAIL wr_rb_data: got %h want %h", obs_data, exp); end
    checks++; if (obs_data[127:64] !== 64'hDEADBEEF_CAFEF00D) begin fails++; $display("FAIL wr_rb_bytes: got %h", obs_data[127:64]); end
  endtask

  task automatic test_eviction();
    bit miss;
    logic [127:0] exp;
    logic [63:0] a;
    for (int n = 1; n <= 8; n++) begin
      a = 64'd8 + 64'(n) * 64'd4096;
      exp = m_read(a, miss);
      run_op(0, 0, a, '0, 3'd0);
      checks++; if (obs_req !== miss) begin fails++; $display("FAIL evict_fill_req n=%0d: got %0b want %0b", n, obs_req, miss); end
      checks++; if (obs_data !== exp) begin fails++; $display("FAIL evict_fill_data n=%0d: got %h want %h", n, obs_data, exp); end
    end
    exp = m_read(64'd8, miss);
    run_op(0, 0, 64'd8, '0, 3'd0);
    checks++; if (obs_req !== 1'b1) begin fails++; $display("FAIL evict_reread_req: got %0b want 1", obs_req); end
    checks++; if (obs_data !== exp) begin fails++; $display("FAIL evict_reread_data: got %h want %h", obs_data, exp); end
  endtask

  task automatic test_flush();
    bit miss;
    logic [127:0] exp;
    m_flush(64'd8);
    run_op(0, 1, 64'd8, '0, 3'd0);
    checks++; if (obs_req !== 1'b1 || obs_clf !== 1'b1) begin fails++; $display("FAIL flush_req_clf: got %0b%0b want 11", obs_req, obs_clf); end
    checks++; if (obs_addr !== 64'd0) begin fails++; $display("FAIL flush_addr: got %h want 0", obs_addr); end
    checks++; if (obs_we !== 1'b0 || obs_data !== '0) begin fails++; $display("FAIL flush_we_data: got %0b %h want 0 0", obs_we, obs_data); end
    exp = m_read(64'd8, miss);
    run_op(0, 0, 64'd8, '0, 3'd0);
    checks++; if (obs_req !== 1'b1) begin fails++; $display("FAIL flush_reread_req: got %0b want 1", obs_req); end
    checks++; if (obs_data !== exp) begin fails++; $display("FAIL flush_reread_data: got %h want %h", obs_data, exp); end
  endtask

  task automatic test_reset_refill();
    bit miss;
    bit saw_pulse = 0;
    logic [127:0] exp;
    int k = 0;
    int cyc = 0;
    m_flush(64'd8);
    run_op(0, 1, 64'd8, '0, 3'd0);
    @(negedge clk);
    enable = 1'b1; write_enable_in = 0; CLF = 0; address_in = 64'd8;
    while (k < 2 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (lower_ack) begin k++; lower_ack = 1'b0; end
      if (lower_req && k < 2) begin lower_ack = 1'b1; data_in = l2_beat(64'd0, k); end
    end
    checks++; if (k !== 2) begin fails++; $display("FAIL rr_beats: got %0d want 2", k); end
    rst = 1'b1; enable = 1'b0;
    #1;
    checks++; if (lower_req !== 1'b0) begin fails++; $display("FAIL rr_lower_req: got %0b want 0", lower_req); end
    checks++; if (address_out !== '0) begin fails++; $display("FAIL rr_address_out: got %h want 0", address_out); end
    m_reset();
    @(negedge clk); rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (cpu_enable) saw_pulse = 1; end
    checks++; if (saw_pulse !== 1'b0) begin fails++; $display("FAIL rr_spurious_pulse: got %0b want 0", saw_pulse); end
    exp = m_read(64'd8, miss);
    run_op(0, 0, 64'd8, '0, 3'd0);
    checks++; if (obs_req !== 1'b1) begin fails++; $display("FAIL rr_reread_req: got %0b want 1", obs_req); end
    checks++; if (obs_data !== exp) begin fails++; $display("FAIL rr_reread_data: got %h want %h", obs_data, exp); end
  endtask

  task automatic test_random();
    bit miss;
    logic [127:0] exp;
    logic [63:0] a, wd;
    logic [2:0] sz;
    int op;
    logic [5:0] sets [3];
    sets[0] = 6'd0; sets[1] = 6'd1; sets[2] = 6'd63;
    for (int i = 0; i < 200; i++) begin
      a = {40'h0, 12'($urandom_range(0, 11)), sets[$urandom_range(0, 2)], 6'($urandom_range(0, 63))};
      wd = {$urandom, $urandom};
      sz = 3'($urandom_range(0, 7));
      op = $urandom_range(0, 19);
      if (op < 11) begin
        exp = m_read(a, miss);
        run_op(0, 0, a, wd, sz);
        checks++; if (obs_req !== miss) begin fails++; $display("FAIL rnd_rd_req i=%0d: got %0b want %0b", i, obs_req, miss); end
        checks++; if (obs_data !== exp) begin fails++; $display("FAIL rnd_rd_data i=%0d: got %h want %h", i, obs_data, exp); end
        if (miss) begin
          checks++; if (obs_addr !== {a[63:6], 6'b0} || obs_we !== 1'b0) begin fails++; $display("FAIL rnd_rd_fwd i=%0d: got %h %0b", i, obs_addr, obs_we); end
        end else begin
          checks++; if (obs_lat !== 2) begin fails++; $display("FAIL rnd_rd_lat i=%0d: got %0d want 2", i, obs_lat); end
        end
      end else if (op < 17) begin
        m_write(a, wd, sz);
        run_op(1, 0, a, wd, sz);
        checks++; if ({obs_req, obs_we, obs_clf} !== 3'b110) begin fails++; $display("FAIL rnd_wr_ctl i=%0d: got %b want 110", i, {obs_req, obs_we, obs_clf}); end
        checks++; if (obs_addr !== a || obs_wdata !== wd || obs_size !== sz) begin fails++; $display("FAIL rnd_wr_fwd i=%0d: got %h %h %0d", i, obs_addr, obs_wdata, obs_size); end
        checks++; if (obs_data !== '0) begin fails++; $display("FAIL rnd_wr_data i=%0d: got %h want 0", i, obs_data); end
      end else begin
        m_flush(a);
        run_op(1'($urandom_range(0, 1)), 1, a, wd, sz);
        checks++; if ({obs_req, obs_we, obs_clf} !== 3'b101) begin fails++; $display("FAIL rnd_fl_ctl i=%0d: got %b want 101", i, {obs_req, obs_we, obs_clf}); end
        checks++; if (obs_addr !== {a[63:6], 6'b0}) begin fails++; $display("FAIL rnd_fl_addr i=%0d: got %h", i, obs_addr); end
      end
      checks++; if (obs_timeout !== 1'b0) begin fails++; $display("FAIL rnd_timeout i=%0d: got %0b want 0", i, obs_timeout); end
      checks++; if (obs_idle_bus !== '0) begin fails++; $display("FAIL rnd_idle_bus i=%0d: got %h want 0", i, obs_idle_bus); end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_read_hit();
    test_write_hit();
    test_eviction();
    test_flush();
    test_reset_refill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/l1_d_cache.md
Name: l1_d_cache

Overview:
- L1 data cache between the CPU-side requester and the next cache level (L2).
- 64-bit byte addresses; write-through, no-write-allocate; 8-way set-associative.
- Read misses refill a full 64-byte line from the lower level in four 128-bit beats.
- Supports per-line flush (CLF), which is forwarded downstream.

Parameters:
- NUM_SETS, 64, number of sets (power of 2); index = address[11:6].
- NUM_WAYS, 8, associativity (power of 2).
- LINE_BYTES, 64, line size; offset = address[5:0]; tag = address[63:12].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  CPU request valid; sampled only in IDLE.
- cpu_enable  out  1  one-cycle done pulse to the CPU.
- write_enable_in  in  1  1=write, 0=read.
- write_data_in  in  64  write data, right-aligned.
- address_in  in  64  request byte address.
- write_size_in  in  3  0=1B, 1=2B, 2=4B, 3=8B; values 4-7 are treated as 8B.
- CLF  in  1  cache line flush request; has priority over write_enable_in.
- data_in  in  128  refill beat from the lower level.
- lower_ack  in  1  lower level beat valid / operation done.
- lower_req  out  1  request to lower level; held high until the final lower_ack.
- data_out  out  128  16-byte chunk address[5:4] of the addressed line; valid while cpu_enable=1.
- write_enable_out  out  1  forwarded write enable.
- write_data_out  out  64  forwarded write data.
- address_out  out  64  forwarded address; line-aligned (low 6 bits zero) for refills.
- write_size_out  out  3  forwarded write size.
- CLF_out  out  1  forwarded flush.
- nops  in  32  debug operation counter from the requester; no functional effect.

Behaviour:
- Reset:
  - All valid bits and replacement pointers cleared.
  - State = IDLE.
  - All outputs 0.
  - Reset mid-operation aborts the operation: lower_req drops immediately and no cpu_enable pulse is issued.
- FSM states: IDLE, LOOKUP, REFILL, WRITE_WAIT, FLUSH_WAIT, RESP.
- IDLE:
  - When enable=1, latch address, data, size, write_enable and CLF.
  - Go to LOOKUP.
  - enable is ignored in every other state. The requester holds its inputs stable until cpu_enable.
- LOOKUP (one cycle): compare the tag across all ways of the indexed set.
- Read hit: go to RESP.
  - data_out = chunk of the hit line.
  - cpu_enable=1 for one cycle.
  - Total latency is 2 cycles from enable to cpu_enable.
- Read miss:
  - Set lower_req=1, address_out = address with bits[5:0] cleared, write_enable_out=0.
  - Go to REFILL.
  - Each lower_ack=1 cycle captures data_in as beat k (k=0..3, beat 0 = bytes 0-15).
  - After beat 3: drop lower_req; write the line into the way selected by the per-set round-robin pointer, which then increments mod NUM_WAYS; set valid; go to RESP with data from the new line.
- Write:
  - On hit, merge the bytes (size from write_size_in, starting at address[5:0]) into the line.
  - On miss, the cache is not modified.
  - Both cases: lower_req=1 with write_enable_out=1, write_data_out, address_out = full address, write_size_out.
  - Go to WRITE_WAIT; the first lower_ack ends it and leads to RESP.
  - data_out = 0 for writes.
- Writes that cross a line boundary: only the bytes within the line are updated locally; the full request is forwarded.
- CLF:
  - Clear valid of any way whose tag matches.
  - lower_req=1, CLF_out=1, address_out = line-aligned address.
  - Go to FLUSH_WAIT; lower_ack leads to RESP.
- The forwarded outputs hold their values while lower_req=1 and return to 0 in IDLE.
- lower_ack outside REFILL, WRITE_WAIT or FLUSH_WAIT is ignored.
- Two ways never hold the same valid tag in one set.

Optional Feature:
- Macro: L1_D_TRACE_EN.
- Defined: on every cpu_enable pulse, print nops, op type (R/W/F), address, hit/miss and data_out in simulation.
- Undefined: no trace code is compiled and the behaviour is identical otherwise.

Test Plan:
- Cold read miss:
  - Stimulus: reset, then read address 8.
  - Response: lower_req=1, address_out=0, write_enable_out=0.
  - Supply 4 beats 0x..00..0x..03; then cpu_enable=1 with data_out = beat0.
- Read hit:
  - Stimulus: read address 8 again.
  - Response: cpu_enable 2 cycles after enable, lower_req stays 0, data_out = beat0. Read 0x30 returns beat3.
- Write hit and read-back:
  - Stimulus: write 8 bytes 0xDEADBEEF_CAFEF00D at address 8.
  - Response: forwarded with write_size_out=3 and address_out=8. After lower_ack, read 8 returns a chunk with bytes 8-15 = the written data.
- Eviction:
  - Stimulus: read addresses 8 + n*4096 for n=1..8, filling set 0.
  - Response: the 9th line evicts way 0; re-reading address 8 misses.
- Flush:
  - Stimulus: CLF at address 8.
  - Response: CLF_out=1, address_out=0. After lower_ack a read of 8 misses.
- Reset during refill:
  - Stimulus: assert rst after beat 1.
  - Response: outputs 0 immediately; a subsequent read of 8 misses.
